// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_WIDTH payload bits LSB first,
// optional even/odd parity, 1 or 2 stop bits; bit timing from a clk-domain divider.
module uart_tx_cfg #(
    parameter int DATA_WIDTH  = 8,
    parameter int CLK_FREQ_HZ = 125_000_000,
    parameter int BAUDRATE    = 9600,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int BAUD_DIV = CLK_FREQ_HZ / BAUDRATE;
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam int BIT_W    = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY == 2);
    localparam logic             PAR_EN    = (PARITY != 0);

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || BAUD_DIV < 2 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
        $error("uart_tx_cfg: illegal parameter combination");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [BIT_W-1:0]      bit_cnt, bit_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic                  par_bit, par_n;
    logic                  tx_n, done_n, tick;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            shreg   <= shreg_n;
            par_bit <= par_n;
            tx      <= tx_n;
            tx_done <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        par_n   = par_bit;
        done_n  = 1'b0;
        tx_n    = 1'b1;
        tick    = (cnt == CNT_LAST);

        if (state != S_IDLE)
            cnt_n = tick ? '0 : cnt + CNT_W'(1);

        case (state)
            S_IDLE: begin
                if (s_valid) begin
                    state_n = S_START;
                    cnt_n   = '0;
                    shreg_n = s_data;
                    par_n   = (^s_data) ^ PAR_ODD;
                end
            end
            S_START: begin
                if (tick) begin
                    state_n = S_DATA;
                    bit_n   = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shreg_n = shreg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_n   = '0;
                        state_n = PAR_EN ? S_PAR : S_STOP;
                    end else begin
                        bit_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            S_PAR: begin
                if (tick) begin
                    state_n = S_STOP;
                    bit_n   = '0;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (bit_cnt == STOP_LAST) begin
                        state_n = S_IDLE;
                        bit_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        bit_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // tx is registered, so it is derived from the state being entered
        case (state_n)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = shreg_n[0];
            S_PAR:   tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
    end

    assign s_ready = (state == S_IDLE);
    assign tx_busy = (state != S_IDLE);

endmodule
